// File: rtl/instr_sequencer.sv
// instr_sequencer: PC owner and valid/ready instruction issuer for the
// 28-bit core; runs NOP delay and JMP locally, resolves BLE via datapath.
// Params : ADDR_WIDTH (PC width), RESET_ADDR (PC after reset),
//          DELAY_WIDTH (NOP delay field width, max 24)
// Clock/Reset          clock, synchronous active-low reset
// iEnable              run permission, only gates FETCH
// iInstruction         ROM data for oAddress (combinational ROM)
// oAddress             registered PC
// oInstruction/oIssueValid/iIssueReady  issue handshake to datapath
// iCondValid/iCondTaken                 BLE outcome, used in BRANCH only
// oBusy                high in DELAY, ISSUE or BRANCH
// Build option: define SEQ_NOP_DELAY_EN to enable NOP delay counting;
// without it every NOP completes in its FETCH cycle.
module instr_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
  parameter int unsigned           DELAY_WIDTH = 24
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iEnable,
  input  logic [27:0]           iInstruction,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [27:0]           oInstruction,
  output logic                  oIssueValid,
  input  logic                  iIssueReady,
  input  logic                  iCondValid,
  input  logic                  iCondTaken,
  output logic                  oBusy
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_BLE = 4'd5;

  // The delay field lives in bits [23:0]; wider would overlap the opcode.
  if (DELAY_WIDTH < 1 || DELAY_WIDTH > 24) begin : g_bad_dw
    $error("instr_sequencer: DELAY_WIDTH must be 1..24");
  end

  typedef enum logic [1:0] {
    FETCH,
    DELAY,
    ISSUE,
    BRANCH
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] tgt_q;
  logic [27:0]           instr_q;
  logic                  vld_q;

  logic [3:0]            op_w;
  logic [3:0]            iss_op_w;
  logic [ADDR_WIDTH-1:0] tgt_w;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign op_w     = iInstruction[27:24];
  assign iss_op_w = instr_q[27:24];
  assign tgt_w    = ADDR_WIDTH'(iInstruction[23:16]);
  // Width-truncated add gives the modulo-2^ADDR_WIDTH wrap.
  assign pc_inc   = pc_q + 1'b1;

`ifdef SEQ_NOP_DELAY_EN
  logic [DELAY_WIDTH-1:0] cnt_q;
  logic [DELAY_WIDTH-1:0] dly_w;

  assign dly_w = iInstruction[DELAY_WIDTH-1:0];
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDR;
      tgt_q   <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
`ifdef SEQ_NOP_DELAY_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        FETCH: begin
          if (iEnable) begin
            unique case (1'b1)
              (op_w == OP_NOP): begin
`ifdef SEQ_NOP_DELAY_EN
                if (dly_w == '0) begin
                  pc_q <= pc_inc;
                end else begin
                  cnt_q   <= dly_w;
                  state_q <= DELAY;
                end
`else
                pc_q <= pc_inc;
`endif
              end
              (op_w == OP_JMP): begin
                pc_q <= tgt_w;
              end
              default: begin
                // BLE target is captured now; the ROM word moves on.
                instr_q <= iInstruction;
                tgt_q   <= tgt_w;
                vld_q   <= 1'b1;
                state_q <= ISSUE;
              end
            endcase
          end
        end
`ifdef SEQ_NOP_DELAY_EN
        DELAY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == DELAY_WIDTH'(1)) begin
            pc_q    <= pc_inc;
            state_q <= FETCH;
          end
        end
`endif
        ISSUE: begin
          if (iIssueReady) begin
            vld_q <= 1'b0;
            if (iss_op_w == OP_BLE) begin
              state_q <= BRANCH;
            end else begin
              pc_q    <= pc_inc;
              state_q <= FETCH;
            end
          end
        end
        BRANCH: begin
          if (iCondValid) begin
            pc_q    <= iCondTaken ? tgt_q : pc_inc;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oIssueValid  = vld_q;
  assign oBusy        = (state_q != FETCH);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed vector table plus hand sequences for
// NOP delay, mid-operation reset and PC wrap.
module tb_instr_sequencer;

  localparam logic [27:0] I_NOP0  = 28'h0000000;
  localparam logic [27:0] I_STO   = 28'h1000123;
  localparam logic [27:0] I_ADD   = 28'h2ABCDEF;
  localparam logic [27:0] I_JUNK  = 28'h2FFFFFF;
  localparam logic [27:0] I_JMPB  = 28'h40B0000;
  localparam logic [27:0] I_JMP2  = 28'h4020000;
  localparam logic [27:0] I_BLE7  = 28'h5070000;
  localparam logic [27:0] I_D4000 = 28'h0000FA0;
  localparam logic [27:0] I_D2000 = 28'h00007D0;

`ifdef SEQ_NOP_DELAY_EN
  localparam int DLY_ON = 1;
`else
  localparam int DLY_ON = 0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iEnable;
  logic [27:0] iInstruction;
  logic [15:0] oAddress;
  logic [27:0] oInstruction;
  logic        oIssueValid;
  logic        iIssueReady;
  logic        iCondValid;
  logic        iCondTaken;
  logic        oBusy;

  int errors = 0;
  int checks = 0;
  int prog_sel = 0;

  instr_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iEnable      (iEnable),
    .iInstruction (iInstruction),
    .oAddress     (oAddress),
    .oInstruction (oInstruction),
    .oIssueValid  (oIssueValid),
    .iIssueReady  (iIssueReady),
    .iCondValid   (iCondValid),
    .iCondTaken   (iCondTaken),
    .oBusy        (oBusy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic        en;
    logic [27:0] ins;
    logic        rdy;
    logic        cv;
    logic        ct;
    logic [15:0] ea;
    logic        ev;
    logic        eb;
    logic [27:0] ei;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic rst, input logic en, input logic [27:0] ins,
    input logic rdy, input logic cv, input logic ct,
    input logic [15:0] ea, input logic ev, input logic eb,
    input logic [27:0] ei);
    vec_t v;
    v.rst = rst; v.en = en; v.ins = ins;
    v.rdy = rdy; v.cv = cv; v.ct = ct;
    v.ea = ea; v.ev = ev; v.eb = eb; v.ei = ei;
    return v;
  endfunction

  // ROM contents for the hand sequences.
  function automatic logic [27:0] prog(input logic [15:0] a);
    case (prog_sel)
      1: return (a == 16'h0000) ? I_D4000 : I_NOP0;
      2: return (a == 16'h0000) ? I_D2000 : I_NOP0;
      3: return (a == 16'hFFFF) ? I_ADD : I_NOP0;
      default: return I_NOP0;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    int n;
    Reset        = 1'b0;
    iEnable      = 1'b0;
    iInstruction = '0;
    iIssueReady  = 1'b0;
    iCondValid   = 1'b0;
    iCondTaken   = 1'b0;

    //           rst  en    ins     rdy cv  ct   ea    ev  eb  ei
    vt[0]  = mk(0, 1, I_STO,  1, 0, 0, 16'd0,  0, 0, 28'd0);
    vt[1]  = mk(0, 1, I_STO,  1, 0, 0, 16'd0,  0, 0, 28'd0);
    vt[2]  = mk(0, 1, I_STO,  1, 0, 0, 16'd0,  0, 0, 28'd0);
    vt[3]  = mk(1, 0, I_STO,  0, 0, 0, 16'd0,  0, 0, 28'd0);
    vt[4]  = mk(1, 1, I_NOP0, 0, 0, 0, 16'd1,  0, 0, 28'd0);
    vt[5]  = mk(1, 1, I_STO,  0, 0, 0, 16'd1,  1, 1, I_STO);
    vt[6]  = mk(1, 1, I_JUNK, 0, 0, 0, 16'd1,  1, 1, I_STO);
    vt[7]  = mk(1, 1, I_JUNK, 0, 1, 1, 16'd1,  1, 1, I_STO);
    vt[8]  = mk(1, 0, I_JUNK, 0, 0, 0, 16'd1,  1, 1, I_STO);
    vt[9]  = mk(1, 1, I_JUNK, 0, 0, 0, 16'd1,  1, 1, I_STO);
    vt[10] = mk(1, 1, I_JUNK, 0, 0, 0, 16'd1,  1, 1, I_STO);
    vt[11] = mk(1, 0, I_JUNK, 1, 0, 0, 16'd2,  0, 0, I_STO);
    vt[12] = mk(1, 1, I_JMPB, 0, 0, 0, 16'd11, 0, 0, I_STO);
    vt[13] = mk(1, 1, I_BLE7, 0, 1, 1, 16'd11, 1, 1, I_BLE7);
    vt[14] = mk(1, 1, I_JUNK, 1, 1, 0, 16'd11, 0, 1, I_BLE7);
    vt[15] = mk(1, 1, I_JUNK, 0, 1, 1, 16'd7,  0, 0, I_BLE7);
    vt[16] = mk(1, 1, I_JMPB, 0, 0, 0, 16'd11, 0, 0, I_BLE7);
    vt[17] = mk(1, 1, I_BLE7, 1, 0, 0, 16'd11, 1, 1, I_BLE7);
    vt[18] = mk(1, 1, I_JUNK, 1, 0, 0, 16'd11, 0, 1, I_BLE7);
    vt[19] = mk(1, 1, I_JUNK, 1, 0, 1, 16'd11, 0, 1, I_BLE7);
    vt[20] = mk(1, 1, I_JUNK, 1, 0, 1, 16'd11, 0, 1, I_BLE7);
    vt[21] = mk(1, 1, I_JUNK, 1, 0, 1, 16'd11, 0, 1, I_BLE7);
    vt[22] = mk(1, 1, I_JUNK, 0, 1, 0, 16'd12, 0, 0, I_BLE7);
    vt[23] = mk(1, 1, I_JMP2, 0, 0, 0, 16'd2,  0, 0, I_BLE7);
    vt[24] = mk(1, 1, I_ADD,  1, 0, 0, 16'd2,  1, 1, I_ADD);
    vt[25] = mk(0, 1, I_ADD,  1, 0, 0, 16'd0,  0, 0, 28'd0);
    vt[26] = mk(1, 1, I_NOP0, 0, 0, 0, 16'd1,  0, 0, 28'd0);

    #1;
    for (int i = 0; i < NV; i++) begin
      Reset        = vt[i].rst;
      iEnable      = vt[i].en;
      iInstruction = vt[i].ins;
      iIssueReady  = vt[i].rdy;
      iCondValid   = vt[i].cv;
      iCondTaken   = vt[i].ct;
      tick();
      check($sformatf("v%0d_addr", i), 32'(oAddress), 32'(vt[i].ea));
      check($sformatf("v%0d_valid", i), 32'(oIssueValid), 32'(vt[i].ev));
      check($sformatf("v%0d_busy", i), 32'(oBusy), 32'(vt[i].eb));
      check($sformatf("v%0d_instr", i), 32'(oInstruction), 32'(vt[i].ei));
    end
    iIssueReady = 1'b0;
    iCondValid  = 1'b0;
    iCondTaken  = 1'b0;
    iEnable     = 1'b1;

    // NOP with delay 4000 at address 0.
    prog_sel = 1;
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    n = 0;
    do begin
      iInstruction = prog(oAddress);
      tick();
      n++;
      if (n == 1) check("nop_busy", 32'(oBusy), 32'(DLY_ON));
    end while (oAddress != 16'd1 && n < 5000);
    check("nop_cycles", 32'(n), (DLY_ON != 0) ? 32'd4001 : 32'd1);
    check("nop_addr", 32'(oAddress), 32'd1);

    // Reset while a delay has 1000 counts left.
    prog_sel = 2;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    iInstruction = prog(oAddress);
    tick();
    for (int k = 0; k < 1000; k++) begin
      iInstruction = prog(oAddress);
      tick();
    end
    check("mid_dly_busy", 32'(oBusy), 32'(DLY_ON));
    Reset = 1'b0;
    tick();
    check("dly_rst_addr", 32'(oAddress), 32'd0);
    check("dly_rst_valid", 32'(oIssueValid), 32'd0);
    check("dly_rst_busy", 32'(oBusy), 32'd0);

    // Walk the PC to 16'hFFFF and issue there; accept wraps to 0.
    prog_sel = 3;
    Reset = 1'b1;
    n = 0;
    while (oAddress != 16'hFFFF && n < 70000) begin
      iInstruction = prog(oAddress);
      tick();
      n++;
    end
    check("walk_cycles", 32'(n), 32'd65535);
    iInstruction = prog(oAddress);
    iIssueReady  = 1'b0;
    tick();
    check("wrap_valid", 32'(oIssueValid), 32'd1);
    check("wrap_hold", 32'(oAddress), 32'hFFFF);
    check("wrap_instr", 32'(oInstruction), 32'(I_ADD));
    iIssueReady = 1'b1;
    tick();
    check("wrap_addr", 32'(oAddress), 32'd0);
    check("wrap_valid0", 32'(oIssueValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch/issue controller for the 28-bit-instruction core. It owns the program counter and drives the ROM address, and it issues each instruction to the datapath over a valid/ready handshake. It executes `NOP` delay and `JMP` locally and resolves `BLE` using the condition result returned by the datapath. It sits between the instruction ROM and the ALU/register-file datapath and replaces free-running PC logic.

## Interface
- ADDR_WIDTH, 16: program counter / ROM address width.
- RESET_ADDR, 0: PC value loaded on reset.
- DELAY_WIDTH, 24: `NOP` delay counter width, from instruction bits [23:0].

- Clock  in  1  single clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low; sampled on the rising edge of Clock.
- iEnable  in  1  run permission; low freezes the FETCH state.
- iInstruction  in  28  ROM output for oAddress (combinational ROM).
- oAddress  out  ADDR_WIDTH  registered PC to the ROM.
- oInstruction  out  28  instruction issued to the datapath.
- oIssueValid  out  1  oInstruction is valid.
- iIssueReady  in  1  datapath accepts oInstruction.
- iCondValid  in  1  branch condition result is valid (BRANCH state only).
- iCondTaken  in  1  branch taken when iCondValid=1.
- oBusy  out  1  high in DELAY, ISSUE or BRANCH.

## Operation
- Field decode:
  - opcode = iInstruction[27:24], compared against `NOP, `JMP and `BLE from Defintions.v.
  - target = {8'b0, iInstruction[23:16]}.
  - delay = iInstruction[23:0].
- States: FETCH, DELAY, ISSUE, BRANCH.
- FETCH, iEnable=0: hold everything.
- FETCH, iEnable=1, decode of iInstruction:
  - `NOP, delay=0: PC+1; stay in FETCH.
  - `NOP, delay>0: cnt<=delay; go to DELAY.
  - `JMP: PC<=target; stay in FETCH. Not issued.
  - Any other opcode (including `BLE): oInstruction<=iInstruction, oIssueValid<=1; go to ISSUE.
- DELAY: cnt decrements each cycle. In the cycle cnt=1: PC+1, go to FETCH. A `NOP` with delay=N occupies N+1 cycles including its FETCH cycle.
- ISSUE: oInstruction and oIssueValid are held stable until iIssueReady=1. At that edge oIssueValid<=0, then:
  - opcode `BLE: go to BRANCH.
  - otherwise: PC+1, go to FETCH.
- BRANCH: wait for iCondValid=1.
  - iCondTaken=1: PC<=target (latched at issue).
  - iCondTaken=0: PC+1.
  - Then go to FETCH.
  - iCondValid outside BRANCH is ignored.
- PC arithmetic is modulo 2^ADDR_WIDTH; 16'hFFFF+1 wraps to 0.
- iEnable affects only FETCH. An instruction in DELAY, ISSUE or BRANCH completes regardless.
- Reset=0 at any edge, in any state (including mid-handshake or mid-delay):
  - state<=FETCH, PC<=RESET_ADDR, cnt<=0.
  - oIssueValid<=0, oInstruction<=0.
  - Any pending issue is dropped.

## Timing
- Reset values: oAddress=RESET_ADDR, oInstruction=28'd0, oIssueValid=0, oBusy=0.
- All outputs are registered; oBusy is decoded from the state register.
- Issue latency: instruction at PC p is seen in FETCH at cycle t. oIssueValid=1 from t+1. With iIssueReady=1 at t+1, oAddress=p+1 at t+2, giving 2 cycles per non-branch instruction.
- `JMP: 1 cycle; oAddress=target at t+1.
- `BLE:
  - with iIssueReady=1 immediately and iCondValid=1 in the first BRANCH cycle: 3 cycles.
  - each extra cycle of ready or cond back-pressure adds 1 cycle.
- Simultaneous Reset=0 and iIssueReady=1: reset wins; no PC advance.

## Configuration
- SEQ_NOP_DELAY_EN defined:
  - `NOP delay counter is implemented as described.
- SEQ_NOP_DELAY_EN undefined:
  - DELAY state and counter are removed.
  - Every `NOP` takes 1 cycle: PC+1 in FETCH, regardless of bits [23:0].
  - Used for fast simulation.

## Test plan
- Reset: hold Reset=0 for 3 cycles → oAddress=0, oIssueValid=0, oInstruction=0, oBusy=0. Release → FETCH at address 0.
- NOP delay (macro on): `NOP with delay=4000 at address 0 → oAddress stays 0 for 4001 cycles, then becomes 1. Macro off → oAddress=1 after 1 cycle.
- Issue back-pressure: `STO at address 1, iIssueReady low for 5 cycles → oInstruction stable and oIssueValid=1 throughout. Ready high → oAddress=2 next cycle.
- Branch: `BLE target 7 at address 11.
  - iCondTaken=1 → oAddress=7.
  - Repeat with iCondTaken=0 → oAddress=12.
  - A 3-cycle gap before iCondValid → FETCH resumes only after it.
- Jump and wrap:
  - `JMP 8'd2 → oAddress=2 after 1 cycle, oIssueValid never asserted.
  - A non-branch instruction at 16'hFFFF, accepted → oAddress=0.
- Reset mid-operation: assert Reset=0 while in ISSUE with oIssueValid=1, and again while in DELAY with count 1000 → next cycle oIssueValid=0, oAddress=0, oBusy=0.
